// File: rtl/sc_player_pkg.sv
// Shared constants for the player FSM and the player row datapath.
package sc_player_pkg;

  localparam int DATAWIDTH_DEFAULT = 8;
  localparam logic [DATAWIDTH_DEFAULT-1:0] INIT_PATTERN_DEFAULT = 8'b0000_0010;

  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  localparam logic [1:0] BLANK_RELOAD = 2'd2;

  typedef enum logic {
    ST_PLAYING = 1'b0,
    ST_CRASHED = 1'b1
  } sc_player_state_t;

endpackage

// File: rtl/sc_player_register_shifter.sv
// Next-row computation for the player car: load, clamped logical shifts.
module sc_player_register_shifter
  import sc_player_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
  input  logic [DATAWIDTH-1:0] i_row,
  input  logic [1:0]           i_shift_sel,
  input  logic                 i_load_n,
  input  logic [DATAWIDTH-1:0] i_data,
  output logic [DATAWIDTH-1:0] o_next_row,
  output logic                 o_blocked
);

  logic w_left;
  logic w_right;

  assign w_left  = i_shift_sel == SHIFT_LEFT;
  assign w_right = i_shift_sel == SHIFT_RIGHT;

  always_comb begin
    o_next_row = i_row;
    o_blocked  = 1'b0;
    unique case (1'b1)
      !i_load_n: o_next_row = i_data;
      w_left: begin
        if (i_row[DATAWIDTH-1]) o_blocked = 1'b1;
        else o_next_row = i_row << 1;
      end
      w_right: begin
        if (i_row[0]) o_blocked = 1'b1;
        else o_next_row = i_row >> 1;
      end
      default: o_next_row = i_row;
    endcase
  end

endmodule

// File: rtl/sc_player_register.sv
// Player row register: applies FSM commands, clamps at the road edges,
// and flags a sticky active-low collision against the obstacle row.
module sc_player_register
  import sc_player_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
  parameter logic [DATAWIDTH-1:0] INIT_PATTERN = INIT_PATTERN_DEFAULT,
  parameter int CRASH_CNT_WIDTH = 4
) (
  input  logic                       SC_PLAYER_STATEMACHINE_CLOCK_50,
  input  logic                       SC_PLAYER_STATEMACHINE_RESET_InHigh,
  input  logic [1:0]                 SC_PLAYER_REGISTER_ShiftSelection_In,
  input  logic                       SC_PLAYER_REGISTER_LoadData_InLow,
  input  logic [DATAWIDTH-1:0]       SC_PLAYER_REGISTER_PlayerData_In,
  input  logic [DATAWIDTH-1:0]       SC_PLAYER_REGISTER_ObstacleRow_In,
  output logic [DATAWIDTH-1:0]       SC_PLAYER_REGISTER_PlayerRow_Out,
  output logic                       SC_PLAYER_REGISTER_Collision_OutLow,
  output logic                       SC_PLAYER_REGISTER_EdgeBlocked_Out,
  output logic [CRASH_CNT_WIDTH-1:0] SC_PLAYER_REGISTER_CrashCount_Out
);

  sc_player_state_t           r_state;
  logic [DATAWIDTH-1:0]       r_row;
  logic                       r_coll_n;
  logic                       r_edge;
  logic [CRASH_CNT_WIDTH-1:0] r_cnt;
  logic [1:0]                 r_blank;

  logic [DATAWIDTH-1:0] w_next_row;
  logic                 w_blocked;
  logic                 w_load;
  logic                 w_overlap;
  logic                 w_hit;

  sc_player_register_shifter #(
    .DATAWIDTH(DATAWIDTH)
  ) u_shifter (
    .i_row      (r_row),
    .i_shift_sel(SC_PLAYER_REGISTER_ShiftSelection_In),
    .i_load_n   (SC_PLAYER_REGISTER_LoadData_InLow),
    .i_data     (SC_PLAYER_REGISTER_PlayerData_In),
    .o_next_row (w_next_row),
    .o_blocked  (w_blocked)
  );

  assign w_load    = !SC_PLAYER_REGISTER_LoadData_InLow;
  assign w_overlap = |(r_row & SC_PLAYER_REGISTER_ObstacleRow_In);
  // A load always wins over a same-cycle overlap; blanking hides reload glitches.
  assign w_hit     = w_overlap && !w_load && (r_blank == 2'd0);

  always_ff @(posedge SC_PLAYER_STATEMACHINE_CLOCK_50
              or posedge SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
    if (SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
      r_state  <= ST_PLAYING;
      r_row    <= INIT_PATTERN;
      r_coll_n <= 1'b1;
      r_edge   <= 1'b0;
      r_cnt    <= '0;
      r_blank  <= 2'd0;
    end else begin
      r_row  <= w_next_row;
      r_edge <= w_blocked;
      if (w_load) r_blank <= BLANK_RELOAD;
      else if (r_blank != 2'd0) r_blank <= r_blank - 2'd1;
      case (r_state)
        ST_PLAYING: begin
          if (w_hit) begin
            r_state  <= ST_CRASHED;
            r_coll_n <= 1'b0;
            if (r_cnt != '1) r_cnt <= r_cnt + CRASH_CNT_WIDTH'(1);
          end
        end
        ST_CRASHED: begin
          if (w_load) begin
            r_state  <= ST_PLAYING;
            r_coll_n <= 1'b1;
          end
        end
        default: r_state <= ST_PLAYING;
      endcase
    end
  end

  assign SC_PLAYER_REGISTER_PlayerRow_Out     = r_row;
  assign SC_PLAYER_REGISTER_Collision_OutLow  = r_coll_n;
  assign SC_PLAYER_REGISTER_EdgeBlocked_Out   = r_edge;
  assign SC_PLAYER_REGISTER_CrashCount_Out    = r_cnt;

endmodule

// File: tb/tb_sc_player_register.sv
// Directed bench for sc_player_register.
module tb_sc_player_register;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic       load_n;
  logic [7:0] data;
  logic [7:0] obs;
  logic [7:0] row;
  logic       coll_n;
  logic       edge_b;
  logic [3:0] cnt;

  int pass_cnt;
  int total;

  sc_player_register dut (
    .SC_PLAYER_STATEMACHINE_CLOCK_50     (clk),
    .SC_PLAYER_STATEMACHINE_RESET_InHigh (rst),
    .SC_PLAYER_REGISTER_ShiftSelection_In(sel),
    .SC_PLAYER_REGISTER_LoadData_InLow   (load_n),
    .SC_PLAYER_REGISTER_PlayerData_In    (data),
    .SC_PLAYER_REGISTER_ObstacleRow_In   (obs),
    .SC_PLAYER_REGISTER_PlayerRow_Out    (row),
    .SC_PLAYER_REGISTER_Collision_OutLow (coll_n),
    .SC_PLAYER_REGISTER_EdgeBlocked_Out  (edge_b),
    .SC_PLAYER_REGISTER_CrashCount_Out   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 2'b00; load_n = 1'b1; data = 8'h00; obs = 8'h00;
    #3;
    total++;
    if (row !== 8'h02) $display("FAIL reset_row got %h want 02", row);
    else pass_cnt++;
    total++;
    if (coll_n !== 1'b1) $display("FAIL reset_coll got %b want 1", coll_n);
    else pass_cnt++;
    total++;
    if (cnt !== 4'h0) $display("FAIL reset_cnt got %h want 0", cnt);
    else pass_cnt++;
    total++;
    if (edge_b !== 1'b0) $display("FAIL reset_edge got %b want 0", edge_b);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load();
    tick();
    data = 8'h10; load_n = 1'b0;
    tick();
    load_n = 1'b1;
    total++;
    if (row !== 8'h10) $display("FAIL load_row got %h want 10", row);
    else pass_cnt++;
  endtask

  task automatic test_shift_left();
    logic [7:0] exp_row [4];
    exp_row[0] = 8'h20; exp_row[1] = 8'h40;
    exp_row[2] = 8'h80; exp_row[3] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      sel = 2'b01;
      tick();
      sel = 2'b00;
      total++;
      if (row !== exp_row[i])
        $display("FAIL left_row[%0d] got %h want %h", i, row, exp_row[i]);
      else pass_cnt++;
      total++;
      if (edge_b !== (i == 3))
        $display("FAIL left_edge[%0d] got %b want %b", i, edge_b, (i == 3));
      else pass_cnt++;
      tick();
      total++;
      if (edge_b !== 1'b0)
        $display("FAIL left_edge_end[%0d] got %b want 0", i, edge_b);
      else pass_cnt++;
    end
  endtask

  task automatic test_shift_right();
    data = 8'h02; load_n = 1'b0;
    tick();
    load_n = 1'b1; sel = 2'b10;
    tick();
    total++;
    if (row !== 8'h01 || edge_b !== 1'b0)
      $display("FAIL right1 got %h/%b want 01/0", row, edge_b);
    else pass_cnt++;
    tick();
    total++;
    if (row !== 8'h01 || edge_b !== 1'b1)
      $display("FAIL right2 got %h/%b want 01/1", row, edge_b);
    else pass_cnt++;
    sel = 2'b11;
    tick();
    total++;
    if (row !== 8'h01 || edge_b !== 1'b0)
      $display("FAIL code11 got %h/%b want 01/0", row, edge_b);
    else pass_cnt++;
    sel = 2'b00;
  endtask

  task automatic test_collision();
    data = 8'h04; load_n = 1'b0;
    tick();
    load_n = 1'b1;
    tick();
    tick();
    obs = 8'h0C;
    tick();
    total++;
    if (coll_n !== 1'b0 || cnt !== 4'h1)
      $display("FAIL crash got %b/%h want 0/1", coll_n, cnt);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (coll_n !== 1'b0 || cnt !== 4'h1)
      $display("FAIL crash_hold got %b/%h want 0/1", coll_n, cnt);
    else pass_cnt++;
    data = 8'h02; load_n = 1'b0;
    tick();
    load_n = 1'b1; obs = 8'h00;
    total++;
    if (coll_n !== 1'b1 || row !== 8'h02)
      $display("FAIL recover got %b/%h want 1/02", coll_n, row);
    else pass_cnt++;
  endtask

  task automatic test_blanking();
    data = 8'h04; load_n = 1'b0; obs = 8'h04;
    tick();
    load_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (coll_n !== 1'b1)
        $display("FAIL blank[%0d] got %b want 1", i, coll_n);
      else pass_cnt++;
      if (i < 2) tick();
    end
    tick();
    total++;
    if (coll_n !== 1'b0 || cnt !== 4'h2)
      $display("FAIL blank_end got %b/%h want 0/2", coll_n, cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    int exp_cnt;
    exp_cnt = 2;
    for (int i = 0; i < 16; i++) begin
      data = 8'h04; load_n = 1'b0; obs = 8'h04;
      tick();
      load_n = 1'b1;
      tick();
      tick();
      tick();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      total++;
      if (coll_n !== 1'b0 || cnt !== 4'(exp_cnt))
        $display("FAIL sat[%0d] got %b/%h want 0/%h", i, coll_n, cnt, exp_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_crashed();
    obs = 8'h00; load_n = 1'b1;
    sel = 2'b01;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (row !== 8'h02 || coll_n !== 1'b1 || cnt !== 4'h0 || edge_b !== 1'b0)
      $display("FAIL async_rst got %h/%b/%h/%b want 02/1/0/0",
               row, coll_n, cnt, edge_b);
    else pass_cnt++;
    sel = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++;
    if (row !== 8'h02 || coll_n !== 1'b1)
      $display("FAIL post_rst got %h/%b want 02/1", row, coll_n);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total = 0;
    test_reset();
    test_load();
    test_shift_left();
    test_shift_right();
    test_collision();
    test_blanking();
    test_saturate();
    test_reset_crashed();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
